// File: rtl/ack_responder.sv
// Responder side of the read/write/ack handshake: services one access against a
// small register file and returns a one-cycle ack. Optional stall input under ACK_RESPONDER_STALL_EN.
module ack_responder #(
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int LATENCY = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          read,
  input  logic          write,
`ifdef ACK_RESPONDER_STALL_EN
  input  logic          stall,
`endif
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  // The accepting edge counts as the first of LATENCY edges; WAIT exits on cnt==0.
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  state_t          state, state_next;
  logic [3:0]      cnt, cnt_next;
  logic            holdoff;
  logic            op_wr;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   mem [2**AW];

  logic            both, req_one, req_held, stall_w;
  logic            accept, commit;
  logic            commit_wr;
  logic [AW-1:0]   commit_addr;
  logic [DW-1:0]   commit_data;
  logic            ack_next, err_next;

  assign both     = read & write;
  assign req_one  = read ^ write;
  assign req_held = op_wr ? write : read;

`ifdef ACK_RESPONDER_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      holdoff <= 1'b0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      mem     <= '{default: '0};
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      holdoff <= (state == ACK);
      ack     <= ack_next;
      err     <= err_next;
      if (accept) begin
        op_wr   <= write;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (commit && commit_wr) begin
        mem[commit_addr] <= commit_data;
      end
      if (commit && !commit_wr) begin
        rdata <= mem[commit_addr];
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        // holdoff swallows the request the requester still shows right after ACK
        if (!holdoff && req_one) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_next = ACK;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (both || !req_held) begin
          state_next = IDLE;
        end else if (stall_w) begin
          state_next = WAIT;
        end else if (cnt == 4'd0) begin
          state_next = ACK;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A LATENCY==1 access commits straight from IDLE, so it uses the live inputs.
  always_comb begin
    busy        = (state != IDLE);
    ack_next    = (state_next == ACK);
    err_next    = both;
    commit_wr   = (state == IDLE) ? write : op_wr;
    commit_addr = (state == IDLE) ? addr  : addr_q;
    commit_data = (state == IDLE) ? wdata : wdata_q;
  end

endmodule

// File: doc/ack_responder.md
Name: ack_responder

Overview:
- Responder end of the req/we/ack handshake.
- Watches the one-hot `read`/`write` level outputs of the requesting FSM and services the access against a small internal register file.
- Returns a single-cycle `ack` after a fixed latency; `ack` is the signal that drives the requesting FSM back to idle.
- Sits beside the FSM in the same clock domain.

Parameters:
- AW, 4, address width; storage depth is 2**AW words.
- DW, 8, data width.
- LATENCY, 3, number of consecutive sampling edges with a request high before `ack` is returned; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- read  in  1  level; requester is in its read state.
- write  in  1  level; requester is in its write state.
- addr  in  AW  access address; sampled with the request.
- wdata  in  DW  write data; sampled with the request.
- ack  out  1  one-cycle completion pulse, registered.
- rdata  out  DW  read data; registered, valid in the `ack` cycle of a read.
- busy  out  1  high in WAIT and ACK states.
- err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous, active-high, on port `reset`.
- Reset values: `ack`=0, `rdata`=0, `busy`=0, `err`=0, state=IDLE, counter=0, all storage words=0.
- States: IDLE, WAIT, ACK.
- IDLE:
  - Exactly one of `read`/`write` sampled high: latch op, `addr` and `wdata`; go to WAIT.
  - Exception: LATENCY=1 goes directly to ACK.
  - Counter loads so that `ack` is high exactly in the cycle after the LATENCY-th consecutive edge with the request sampled high.
- WAIT:
  - Counter decrements each edge.
  - The latched op's input must stay high.
  - Expiry: go to ACK.
- ACK:
  - `ack`=1 for exactly one cycle.
  - Write: storage[latched addr] <= latched wdata at the edge that enters ACK.
  - Read: `rdata` <= storage[latched addr], visible in the ACK cycle.
  - Next state is always IDLE.
  - The requester drops `read`/`write` one cycle after it samples `ack`, so the request is still high at the edge leaving ACK. It must not retrigger: IDLE ignores requests for the first cycle after ACK (holdoff bit).
- `rdata` holds its value outside read ACK cycles; writes never change `rdata`.
- Abort: request input drops (or flips to the other op) while in WAIT → return to IDLE. No `ack`, no storage write, `rdata` unchanged, no `err`.
- Protocol error: `read` and `write` sampled high together in any state → `err` pulse next cycle.
  - In IDLE: stay IDLE.
  - In WAIT: abort as above.
  - Has no effect in ACK beyond the `err` pulse.
- Read-after-write to the same address returns the newly written data.
- Reset asserted mid-transaction: next cycle is in reset state; `ack` is never emitted for the aborted access.
- `addr`/`wdata` changes after the request is latched are ignored.

Optional Feature:
- Macro: ACK_RESPONDER_STALL_EN.
- Defined:
  - Adds input port `stall` (1 bit).
  - While `stall`=1 in WAIT, the counter holds; the request-drop abort still applies.
  - `stall`=1 at the edge that would enter ACK delays ACK until the first edge with `stall`=0.
  - `stall` is ignored in IDLE and ACK.
- Undefined: no `stall` port; latency is exactly LATENCY.

Test Plan:
- Reset and idle: hold `reset`=1 for 2 cycles, then release with no requests for 5 cycles → `ack`=0, `busy`=0, `err`=0, `rdata`=0 throughout.
- Write then read (LATENCY=3): `write`=1, `addr`=4'h5, `wdata`=8'hA7; drop `write` one cycle after `ack`. Then `read`=1, `addr`=4'h5 → each `ack` high exactly 3 edges after the request is sampled and for one cycle only; `rdata`=8'hA7 in the read `ack` cycle.
- Holdoff: keep `read`=1 for one cycle after `ack` → no second `ack`, state returns to IDLE.
- Abort: `write`=1 to `addr`=4'h2 with `wdata`=8'h3C, dropped after 1 edge; then read `addr`=4'h2 → no `ack` for the write; read returns 8'h00.
- Protocol error: `read`=`write`=1 for one cycle → `err`=1 for one cycle, no `ack`, `busy`=0.
- Mid-operation reset: `reset`=1 in WAIT → `busy`=0 and `ack`=0 next cycle; a subsequent read of the previously written address returns 8'h00.
- Stall (ACK_RESPONDER_STALL_EN defined): read request with `stall`=1 for 4 cycles during WAIT → `ack` arrives 4 cycles later than without stall.
